// File: rtl/enc8b10b_pkg.sv
// rtl/enc8b10b_pkg.sv - shared 8B/10B constants, comma patterns and aligner state type
package enc8b10b_pkg;

  // K28.5 code groups for both running disparities, bit "a" in [9].
  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  // 7-bit comma sequences (both polarities) found at the head of K28.1/5/7.
  localparam logic [6:0] COMMA_P = 7'b0011111;
  localparam logic [6:0] COMMA_N = 7'b1100000;

  // Number of candidate bit offsets inside a 10-bit symbol.
  localparam int NUM_OFFSETS = 10;

  typedef enum logic [1:0] {
    LOS  = 2'd0,
    ACQ  = 2'd1,
    SYNC = 2'd2
  } align_state_t;

  // True when a 7-bit slice of the line is a comma of either polarity.
  function automatic logic is_comma7(input logic [6:0] bits);
    return (bits == COMMA_P) || (bits == COMMA_N);
  endfunction

endpackage

// File: rtl/comma_detect.sv
// rtl/comma_detect.sv - combinational comma search over a 20-bit two-word window
module comma_detect
  import enc8b10b_pkg::*;
(
  input  logic [19:0] window,
  output logic        hit,
  output logic [3:0]  k,
  output logic [9:0]  hit_vec
);

  // Candidate k starts at window[19-k]; its first seven bits decide the comma.
  // The deepest candidate (k=9) ends at window[4], so the tail is never inspected.
  logic unused_tail;
  assign unused_tail = ^window[3:0];

  // Per-offset comma flags.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_OFFSETS; i++) begin
      hit_vec[i] = is_comma7(window[19-i -: 7]);
    end
  end

  // Lowest offset wins: scan from high to low so the lowest hit is written last.
  always_comb begin
    hit = 1'b0;
    k   = 4'd0;
    for (int i = NUM_OFFSETS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit = 1'b1;
        k   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/comma_align.sv
// rtl/comma_align.sv - K28.5 word aligner with lock/loss hysteresis and one output register
module comma_align
  import enc8b10b_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 3,
  parameter int MAX_GAP  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       din_vld,
  output logic [9:0] dout,
  output logic       dout_vld,
  output logic       is_comma,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int CNT_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);
  localparam int GAP_W  = $clog2(MAX_GAP + 1);

  localparam logic [CNT_W-1:0]  CNT_LOCK  = CNT_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] MISS_LOSS = MISS_W'(LOSS_CNT);
  localparam logic [GAP_W-1:0]  GAP_LOSS  = GAP_W'(MAX_GAP);

  // Registered state.
  logic [9:0]        prev;
  logic              primed;
  align_state_t      state_q;
  logic [3:0]        offset_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [MISS_W-1:0] miss_q;
  logic [GAP_W-1:0]  gap_q;

  // Next-state values.
  align_state_t      state_d;
  logic [3:0]        offset_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [MISS_W-1:0] miss_d;
  logic [GAP_W-1:0]  gap_d;

  // Detection results for the current window.
  logic [19:0] window;
  logic        hit;
  logic [3:0]  hit_k;
  logic [9:0]  hit_vec;
  logic        aligned;
  logic        load;
  logic [3:0]  off_cur;
  logic [9:0]  cand;
  logic        cand_comma;

  // Saturating increments.
  logic [CNT_W-1:0]  cnt_inc;
  logic [MISS_W-1:0] miss_inc;
  logic [GAP_W-1:0]  gap_inc;

  // The last window bit is never part of any candidate.
  logic unused_lsb;
  assign unused_lsb = window[0];

  assign window = {prev, din};

  comma_detect u_detect (
    .window  (window),
    .hit     (hit),
    .k       (hit_k),
    .hit_vec (hit_vec)
  );

  assign cnt_inc  = (cnt_q  == '1) ? cnt_q  : cnt_q  + 1'b1;
  assign miss_inc = (miss_q == '1) ? miss_q : miss_q + 1'b1;
  assign gap_inc  = (gap_q  == '1) ? gap_q  : gap_q  + 1'b1;

  // Comma present at the stored offset.
  always_comb begin
    aligned = 1'b0;
    for (int i = 0; i < NUM_OFFSETS; i++) begin
      if (offset_q == 4'(i)) begin
        aligned = hit_vec[i];
      end
    end
  end

  // Alignment FSM: next state, offset load and counter updates for the current word.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    cnt_d    = cnt_q;
    miss_d   = miss_q;
    gap_d    = gap_q;
    load     = 1'b0;
    if (din_vld && primed) begin
      unique case (state_q)
        LOS: begin
          if (hit) begin
            load     = 1'b1;
            offset_d = hit_k;
            cnt_d    = CNT_W'(1);
            if (CNT_W'(1) >= CNT_LOCK) begin
              state_d = SYNC;
              gap_d   = '0;
              miss_d  = '0;
            end else begin
              state_d = ACQ;
            end
          end
        end
        ACQ: begin
          if (aligned) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_LOCK) begin
              state_d = SYNC;
              gap_d   = '0;
              miss_d  = '0;
            end
          end else if (hit) begin
            load     = 1'b1;
            offset_d = hit_k;
            cnt_d    = CNT_W'(1);
          end
        end
        SYNC: begin
          if (aligned) begin
            gap_d  = '0;
            miss_d = '0;
          end else begin
            gap_d = gap_inc;
            if (hit) begin
              miss_d = miss_inc;
            end
            if ((gap_inc >= GAP_LOSS) || (hit && (miss_inc >= MISS_LOSS))) begin
              state_d = LOS;
            end
          end
        end
        default: state_d = LOS;
      endcase
    end
  end

  // Offset used for this word's output: a freshly loaded k takes effect immediately.
  assign off_cur = load ? hit_k : offset_q;

  // Candidate code group and its comma flag at the output offset.
  always_comb begin
    cand       = 10'd0;
    cand_comma = 1'b0;
    for (int i = 0; i < NUM_OFFSETS; i++) begin
      if (off_cur == 4'(i)) begin
        cand       = window[19-i -: 10];
        cand_comma = hit_vec[i];
      end
    end
  end

  // Window history, priming flag, state and counters advance only on valid words.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= 10'd0;
      primed   <= 1'b0;
      state_q  <= LOS;
      offset_q <= 4'd0;
      cnt_q    <= '0;
      miss_q   <= '0;
      gap_q    <= '0;
    end else if (din_vld) begin
      prev     <= din;
      primed   <= 1'b1;
      state_q  <= state_d;
      offset_q <= offset_d;
      cnt_q    <= cnt_d;
      miss_q   <= miss_d;
      gap_q    <= gap_d;
    end
  end

  // Output register: a word is emitted only when it leaves the aligner in SYNC.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= 10'd0;
      dout_vld <= 1'b0;
      is_comma <= 1'b0;
    end else if (din_vld) begin
      dout     <= cand;
      dout_vld <= (state_d == SYNC);
      is_comma <= (state_d == SYNC) && cand_comma;
    end else begin
      dout_vld <= 1'b0;
      is_comma <= 1'b0;
    end
  end

  assign locked = (state_q == SYNC);
  assign offset = offset_q;

endmodule

// File: tb/tb_comma_align.sv
// tb/tb_comma_align.sv - directed table-driven and sequence checks for comma_align
module tb_comma_align;
  import enc8b10b_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] din = 10'd0;
  logic       din_vld = 1'b0;
  logic [9:0] dout;
  logic       dout_vld;
  logic       is_comma;
  logic       locked;
  logic [3:0] offset;

  always #5 clk = ~clk;

  comma_align #(
    .LOCK_CNT (3),
    .LOSS_CNT (3),
    .MAX_GAP  (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_vld  (din_vld),
    .dout     (dout),
    .dout_vld (dout_vld),
    .is_comma (is_comma),
    .locked   (locked),
    .offset   (offset)
  );

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [9:0] din;
    logic [9:0] e_dout;
    logic       e_vld;
    logic       e_comma;
    logic       e_locked;
    logic [3:0] e_off;
    logic       chk_dout;
  } vec_t;

  vec_t tbl[8];
  logic bits_q[$];
  logic [9:0] data_pat[3];

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic step(input logic r, input logic v, input logic [9:0] d);
    rst = r;
    din_vld = v;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push_sym(input logic [9:0] s);
    for (int i = 9; i >= 0; i--) bits_q.push_back(s[i]);
  endtask

  task automatic push_bit(input logic b);
    bits_q.push_back(b);
  endtask

  // Alternating K28.5 symbols starting with RD-; index 0 is RD-.
  task automatic push_commas(input int n, input int first);
    for (int j = first; j < first + n; j++) push_sym((j % 2 == 0) ? K28_5_RDN : K28_5_RDP);
  endtask

  task automatic send_next();
    logic [9:0] w;
    w = 10'd0;
    for (int i = 9; i >= 0; i--) begin
      if (bits_q.size() > 0) w[i] = bits_q.pop_front();
    end
    step(1'b0, 1'b1, w);
  endtask

  initial begin
    data_pat[0] = 10'b1010101010;
    data_pat[1] = 10'b0101010101;
    data_pat[2] = 10'b1001100110;

    //        rst   vld   din        e_dout     vld comma lock off  chk_dout
    tbl[0] = '{1'b1, 1'b0, 10'd0,     10'd0,     0,  0,    0,   0,   1'b1};
    tbl[1] = '{1'b0, 1'b1, K28_5_RDN, 10'd0,     0,  0,    0,   0,   1'b0};
    tbl[2] = '{1'b0, 1'b1, K28_5_RDP, 10'd0,     0,  0,    0,   0,   1'b0};
    tbl[3] = '{1'b0, 1'b1, K28_5_RDN, 10'd0,     0,  0,    0,   0,   1'b0};
    tbl[4] = '{1'b0, 1'b1, K28_5_RDP, K28_5_RDN, 1,  1,    1,   0,   1'b1};
    tbl[5] = '{1'b0, 1'b0, 10'h155,   10'd0,     0,  0,    1,   0,   1'b0};
    tbl[6] = '{1'b0, 1'b1, K28_5_RDN, K28_5_RDP, 1,  1,    1,   0,   1'b1};
    tbl[7] = '{1'b0, 1'b1, K28_5_RDP, K28_5_RDN, 1,  1,    1,   0,   1'b1};

    for (int r = 0; r < 8; r++) begin
      step(tbl[r].rst, tbl[r].vld, tbl[r].din);
      if (tbl[r].chk_dout) check($sformatf("tbl%0d dout", r), dout, tbl[r].e_dout);
      check($sformatf("tbl%0d dout_vld", r), 10'(dout_vld), 10'(tbl[r].e_vld));
      check($sformatf("tbl%0d is_comma", r), 10'(is_comma), 10'(tbl[r].e_comma));
      check($sformatf("tbl%0d locked", r), 10'(locked), 10'(tbl[r].e_locked));
      check($sformatf("tbl%0d offset", r), 10'(offset), 10'(tbl[r].e_off));
    end

    // Comma stream delayed by every shift 0..9: same lock point and output.
    for (int s = 0; s < 10; s++) begin
      step(1'b1, 1'b0, 10'd0);
      bits_q.delete();
      for (int i = 0; i < s; i++) push_bit((i % 2 == 0) ? 1'b1 : 1'b0);
      push_commas(6, 0);
      send_next(); send_next(); send_next();
      check($sformatf("shift%0d pre-lock", s), 10'(locked), 10'd0);
      send_next();
      check($sformatf("shift%0d locked", s), 10'(locked), 10'd1);
      check($sformatf("shift%0d offset", s), 10'(offset), 10'(s));
      check($sformatf("shift%0d dout", s), dout, K28_5_RDN);
      check($sformatf("shift%0d is_comma", s), 10'(is_comma), 10'd1);
      send_next();
      check($sformatf("shift%0d dout2", s), dout, K28_5_RDP);
      check($sformatf("shift%0d vld2", s), 10'(dout_vld), 10'd1);
    end

    // One-bit slip while locked: three misaligned commas drop lock, then relock at 1.
    step(1'b1, 1'b0, 10'd0);
    bits_q.delete();
    push_commas(6, 0);
    push_bit(1'b1);
    push_commas(8, 6);
    for (int i = 0; i < 7; i++) send_next();
    check("slip locked w6", 10'(locked), 10'd1);
    check("slip comma w6", 10'(is_comma), 10'd1);
    send_next();
    check("slip miss1 locked", 10'(locked), 10'd1);
    check("slip miss1 vld", 10'(dout_vld), 10'd1);
    check("slip miss1 comma", 10'(is_comma), 10'd0);
    check("slip miss1 dout", dout, 10'b1001111101);
    send_next();
    check("slip miss2 locked", 10'(locked), 10'd1);
    send_next();
    check("slip loss locked", 10'(locked), 10'd0);
    check("slip loss vld", 10'(dout_vld), 10'd0);
    send_next();
    check("slip reacq offset", 10'(offset), 10'd1);
    check("slip reacq locked", 10'(locked), 10'd0);
    send_next();
    check("slip reacq2 locked", 10'(locked), 10'd0);
    send_next();
    check("slip relock", 10'(locked), 10'd1);
    check("slip relock offset", 10'(offset), 10'd1);
    check("slip relock dout", dout, K28_5_RDP);
    check("slip relock comma", 10'(is_comma), 10'd1);

    // Locked, then comma-free data: lock drops when the 64th data word is emitted.
    step(1'b1, 1'b0, 10'd0);
    step(1'b0, 1'b1, K28_5_RDN);
    step(1'b0, 1'b1, K28_5_RDP);
    step(1'b0, 1'b1, K28_5_RDN);
    step(1'b0, 1'b1, K28_5_RDP);
    check("gap locked", 10'(locked), 10'd1);
    for (int i = 0; i < 65; i++) begin
      step(1'b0, 1'b1, data_pat[i % 3]);
      if (i == 0) check("gap last comma", 10'(is_comma), 10'd1);
      if (i == 1) begin
        check("gap data0 dout", dout, data_pat[0]);
        check("gap data0 comma", 10'(is_comma), 10'd0);
      end
      if (i == 63) begin
        check("gap 63 locked", 10'(locked), 10'd1);
        check("gap 63 dout", dout, data_pat[62 % 3]);
      end
      if (i == 64) begin
        check("gap 64 locked", 10'(locked), 10'd0);
        check("gap 64 vld", 10'(dout_vld), 10'd0);
      end
    end

    // ACQ restarts on a comma at a new offset: 2 at k=2, then lock needs 3 at k=5.
    step(1'b1, 1'b0, 10'd0);
    bits_q.delete();
    push_bit(1'b1); push_bit(1'b0);
    push_commas(2, 0);
    push_bit(1'b1); push_bit(1'b0); push_bit(1'b1);
    push_commas(4, 2);
    send_next(); send_next(); send_next();
    check("acq k2 offset", 10'(offset), 10'd2);
    check("acq k2 locked", 10'(locked), 10'd0);
    send_next();
    check("acq k5 offset", 10'(offset), 10'd5);
    check("acq k5 locked", 10'(locked), 10'd0);
    send_next();
    check("acq k5 cnt2 locked", 10'(locked), 10'd0);
    send_next();
    check("acq k5 lock", 10'(locked), 10'd1);
    check("acq k5 lock offset", 10'(offset), 10'd5);
    check("acq k5 dout", dout, K28_5_RDN);

    // Reset while locked at offset 5, then reacquire with idle gaps between words.
    step(1'b1, 1'b1, K28_5_RDN);
    check("rst dout", dout, 10'd0);
    check("rst vld", 10'(dout_vld), 10'd0);
    check("rst comma", 10'(is_comma), 10'd0);
    check("rst locked", 10'(locked), 10'd0);
    check("rst offset", 10'(offset), 10'd0);
    step(1'b0, 1'b1, K28_5_RDN);
    step(1'b0, 1'b0, 10'h3FF);
    step(1'b0, 1'b1, K28_5_RDP);
    step(1'b0, 1'b0, 10'h3FF);
    step(1'b0, 1'b1, K28_5_RDN);
    check("reacq w2 locked", 10'(locked), 10'd0);
    step(1'b0, 1'b0, 10'h3FF);
    check("reacq idle locked", 10'(locked), 10'd0);
    step(1'b0, 1'b1, K28_5_RDP);
    check("reacq lock", 10'(locked), 10'd1);
    check("reacq dout", dout, K28_5_RDN);
    check("reacq vld", 10'(dout_vld), 10'd1);
    step(1'b0, 1'b0, 10'h3FF);
    check("reacq idle vld", 10'(dout_vld), 10'd0);
    check("reacq idle hold", 10'(locked), 10'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
